ma_dbus_ctrl: RTL and testbench
===============================

// Module: ma_dbus_ctrl
// PURPOSE
//  Memory-access stage data-bus controller that consumes the executor result as the effective address of loads/stores.
//  Issues one req/gnt/rvalid bus transaction per instruction and stalls upstream while the transaction is open.
//  Builds byte enables and replicated store data; aligns and sign/zero-extends load data.
//  Reports misaligned accesses and bus errors to the MA stage.
// PARAMETERS
//  WAIT_LIMIT  0  max cycles spent in REQ or WAIT before forced bus error; 0 disables the timeout
// PORTS
//  s_clk_i         in   1   clock
//  s_reset_i       in   1   reset, synchronous, active-high
//  s_valid_i       in   1   EX presents a finished load/store this cycle
//  s_store_i       in   1   1=store, 0=load
//  s_size_i        in   2   0=byte, 1=half, 2=word, 3=reserved
//  s_unsigned_i    in   1   load zero-extends (LBU/LHU)
//  s_addr_i        in   32  effective address (executor result)
//  s_wdata_i       in   32  store operand (rs2)
//  s_flush_i       in   1   kill the in-flight or presented instruction
//  s_stall_o       out  1   hold upstream stages
//  s_done_o        out  1   one-cycle completion pulse
//  s_rdata_o       out  32  aligned, extended load data; valid with s_done_o
//  s_misalign_o    out  1   with s_done_o: misaligned or reserved-size access, no bus cycle issued
//  s_buserr_o      out  1   with s_done_o: bus error or timeout
//  s_dbus_req_o    out  1   bus request
//  s_dbus_we_o     out  1   write enable
//  s_dbus_addr_o   out  32  word address, bits [1:0] = 0
//  s_dbus_be_o     out  4   byte enables
//  s_dbus_wdata_o  out  32  write data
//  s_dbus_gnt_i    in   1   request accepted
//  s_dbus_rvalid_i in   1   response valid (for both loads and stores)
//  s_dbus_rdata_i  in   32  read data
//  s_dbus_err_i    in   1   response error, qualified by rvalid
// BEHAVIOUR
//  Reset: FSM=IDLE, kill=0; all outputs 0. A reset mid-transaction drops s_dbus_req_o at once; the bus is reset together with the core.
//  FSM states: IDLE, REQ, WAIT, DONE. All bus outputs are registered and stay stable while in REQ.
//  IDLE: valid & !flush -> accept. Latch offset=addr[1:0], size, unsigned, we, be, wdata; set dbus_addr={addr[31:2],2'b0}.
//    Misaligned (half & addr[0]; word & addr[1:0]!=0) or size==3 -> DONE with misalign=1; no bus cycle is issued.
//    Otherwise -> REQ.
//  BE encoding: byte 4'b0001<<off; half 4'b0011<<off; word 4'b1111.
//  WDATA encoding: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
//  REQ: req_o=1. Once raised, req stays high until gnt. On gnt -> WAIT and req_o=0 next cycle.
//  WAIT: on rvalid -> DONE.
//    err=1: buserr=1, rdata=0.
//    Load: rdata = (dbus_rdata>>(8*off)) cut to the access size; sign-extended unless unsigned.
//    Store: rdata=0.
//  DONE: s_done_o=1 for exactly one cycle, then IDLE. rdata, misalign and buserr are valid only in this cycle and are 0 otherwise.
//    s_valid_i is ignored in DONE: it is the same instruction, which leaves EX at this edge.
//  s_stall_o = (IDLE & s_valid_i & !s_flush_i) | REQ | WAIT. It is 0 in DONE.
//  Zero-wait load or store: accept T0, gnt T1, rvalid T2, done T3. Misaligned access: accept T0, done T1.
//  Flush:
//    In IDLE: nothing is accepted.
//    In REQ or WAIT: set kill. The handshake runs to completion (req held until gnt, rvalid consumed). Then IDLE with no done pulse.
//    In DONE: no effect; the MA stage gates the pulse.
//  rvalid in IDLE, REQ or DONE is a protocol violation: ignored; simulation assertion.
//  Timeout (WAIT_LIMIT>0): a counter clears on entry to REQ and on entry to WAIT and counts each cycle spent there.
//    Reaching WAIT_LIMIT -> DONE with buserr=1 (or IDLE if kill); req is dropped.
//  A new access is accepted only from IDLE. Back-to-back accesses therefore cost one idle cycle after DONE.
// TESTING
//  1. LB, addr=0x1003, rdata=0x80FF_FF00, gnt/rvalid with no wait
//     -> addr_o=0x1000, be=4'b1000, done at T3, rdata_o=0xFFFF_FF80; LBU gives 0x0000_0080.
//  2. SH, addr=0x2002, wdata=0x1234_ABCD, gnt after 3 cycles
//     -> req held 4 cycles, be=4'b1100, wdata_o=0xABCD_ABCD, we=1, stall high until DONE.
//  3. LW, addr=0x3002 -> no req ever asserted, done+misalign at T1, stall high only in T0; size=3 behaves the same.
//  4. LW, addr=0x4000, flush in WAIT, rvalid 2 cycles later -> no done pulse, IDLE after rvalid, a new LW accepted next cycle.
//  5. LW with err=1 -> done+buserr, rdata_o=0.
//     WAIT_LIMIT=8, gnt never asserted -> buserr after 8 REQ cycles, req dropped.
//  6. Reset asserted in WAIT -> next cycle all outputs 0, FSM IDLE; a late rvalid is ignored.

Source files
------------

// File: rtl/ma_dbus_ctrl.sv
// Memory-access stage data-bus controller: one req/gnt/rvalid transaction per load/store,
// byte-lane steering for stores, alignment and sign/zero extension for loads.
module ma_dbus_ctrl #(
  parameter int unsigned WAIT_LIMIT = 0
) (
  input  logic        s_clk_i,
  input  logic        s_reset_i,
  input  logic        s_valid_i,
  input  logic        s_store_i,
  input  logic [1:0]  s_size_i,
  input  logic        s_unsigned_i,
  input  logic [31:0] s_addr_i,
  input  logic [31:0] s_wdata_i,
  input  logic        s_flush_i,
  output logic        s_stall_o,
  output logic        s_done_o,
  output logic [31:0] s_rdata_o,
  output logic        s_misalign_o,
  output logic        s_buserr_o,
  output logic        s_dbus_req_o,
  output logic        s_dbus_we_o,
  output logic [31:0] s_dbus_addr_o,
  output logic [3:0]  s_dbus_be_o,
  output logic [31:0] s_dbus_wdata_o,
  input  logic        s_dbus_gnt_i,
  input  logic        s_dbus_rvalid_i,
  input  logic [31:0] s_dbus_rdata_i,
  input  logic        s_dbus_err_i
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} state_t;

  state_t      r_state;
  logic        r_kill;
  logic        r_orphan;
  logic [1:0]  r_off;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [31:0] r_cnt;
  logic        r_req, r_we, r_done, r_misalign, r_buserr;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_be;

  logic        w_misalign;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shift;
  logic [31:0] w_load;
  logic        w_timeout;
  logic        w_kill;

  assign w_misalign = (s_size_i == 2'd3) ||
                      ((s_size_i == 2'd1) && s_addr_i[0]) ||
                      ((s_size_i == 2'd2) && (s_addr_i[1:0] != 2'b00));
  assign w_shift    = s_dbus_rdata_i >> {r_off, 3'b000};
  assign w_timeout  = (WAIT_LIMIT != 0) && (r_cnt == WAIT_LIMIT - 1);
  assign w_kill     = r_kill | s_flush_i;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = s_wdata_i;
    case (s_size_i)
      2'd0: begin
        w_be    = 4'b0001 << s_addr_i[1:0];
        w_wdata = {4{s_wdata_i[7:0]}};
      end
      2'd1: begin
        w_be    = 4'b0011 << s_addr_i[1:0];
        w_wdata = {2{s_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_load = w_shift;
    case (r_size)
      2'd0:    w_load = {{24{~r_uns & w_shift[7]}}, w_shift[7:0]};
      2'd1:    w_load = {{16{~r_uns & w_shift[15]}}, w_shift[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge s_clk_i) begin
    if (s_reset_i) begin
      // Remember an abandoned bus cycle so its late response is tolerated once.
      r_orphan   <= r_orphan | (r_state == ST_REQ) | (r_state == ST_WAIT);
      r_state    <= ST_IDLE;
      r_kill     <= 1'b0;
      r_off      <= '0;
      r_size     <= '0;
      r_uns      <= 1'b0;
      r_cnt      <= '0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_done     <= 1'b0;
      r_rdata    <= '0;
      r_misalign <= 1'b0;
      r_buserr   <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_rdata    <= '0;
      r_misalign <= 1'b0;
      r_buserr   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (s_dbus_rvalid_i) r_orphan <= 1'b0;
          if (s_valid_i && !s_flush_i) begin
            r_orphan <= 1'b0;
            r_off    <= s_addr_i[1:0];
            r_size   <= s_size_i;
            r_uns    <= s_unsigned_i;
            r_we     <= s_store_i;
            r_be     <= w_be;
            r_wdata  <= w_wdata;
            r_addr   <= {s_addr_i[31:2], 2'b00};
            if (w_misalign) begin
              r_state    <= ST_DONE;
              r_done     <= 1'b1;
              r_misalign <= 1'b1;
            end else begin
              r_state <= ST_REQ;
              r_req   <= 1'b1;
              r_cnt   <= '0;
            end
          end
        end
        ST_REQ: begin
          if (s_flush_i) r_kill <= 1'b1;
          if (s_dbus_gnt_i) begin
            r_state <= ST_WAIT;
            r_req   <= 1'b0;
            r_cnt   <= '0;
          end else if (w_timeout) begin
            r_req  <= 1'b0;
            r_kill <= 1'b0;
            if (w_kill) begin
              r_state <= ST_IDLE;
            end else begin
              r_state  <= ST_DONE;
              r_done   <= 1'b1;
              r_buserr <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        ST_WAIT: begin
          if (s_flush_i) r_kill <= 1'b1;
          if (s_dbus_rvalid_i || w_timeout) begin
            r_kill <= 1'b0;
            if (w_kill) begin
              r_state <= ST_IDLE;
            end else begin
              r_state  <= ST_DONE;
              r_done   <= 1'b1;
              r_buserr <= !s_dbus_rvalid_i || s_dbus_err_i;
              r_rdata  <= (!s_dbus_rvalid_i || s_dbus_err_i || r_we) ? '0 : w_load;
            end
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  a_rvalid_only_in_wait: assert property (@(posedge s_clk_i) disable iff (s_reset_i)
    s_dbus_rvalid_i |-> ((r_state == ST_WAIT) || r_orphan));

  assign s_stall_o      = ((r_state == ST_IDLE) && s_valid_i && !s_flush_i) ||
                          (r_state == ST_REQ) || (r_state == ST_WAIT);
  assign s_done_o       = r_done;
  assign s_rdata_o      = r_rdata;
  assign s_misalign_o   = r_misalign;
  assign s_buserr_o     = r_buserr;
  assign s_dbus_req_o   = r_req;
  assign s_dbus_we_o    = r_we;
  assign s_dbus_addr_o  = r_addr;
  assign s_dbus_be_o    = r_be;
  assign s_dbus_wdata_o = r_wdata;

endmodule

// File: tb/tb_ma_dbus_ctrl.sv
// Directed bench for ma_dbus_ctrl: loads/stores of every size, misalignment, bus error,
// timeout, flush during a transaction and reset mid-transaction.
module tb_ma_dbus_ctrl;

  logic        clk = 1'b0;
  logic        rst, valid, store, uns, flush, gnt, rvalid, err;
  logic [1:0]  size;
  logic [31:0] addr, wdata, brdata;
  logic        stall_o, done_o, mis_o_w, berr_o_w, req_o, we_o_w;
  logic [31:0] rdata_o, addr_o, wdata_o;
  logic [3:0]  be_o_w;

  int n_chk = 0;
  int n_bad = 0;

  int          lat, reqc;
  logic [31:0] a_o, wd_o, rd_o;
  logic [3:0]  be_o;
  logic        we_o, mis_o, berr_o, sbad;

  always #5 clk = ~clk;

  ma_dbus_ctrl #(.WAIT_LIMIT(8)) dut (
    .s_clk_i(clk), .s_reset_i(rst), .s_valid_i(valid), .s_store_i(store),
    .s_size_i(size), .s_unsigned_i(uns), .s_addr_i(addr), .s_wdata_i(wdata),
    .s_flush_i(flush), .s_stall_o(stall_o), .s_done_o(done_o), .s_rdata_o(rdata_o),
    .s_misalign_o(mis_o_w), .s_buserr_o(berr_o_w), .s_dbus_req_o(req_o),
    .s_dbus_we_o(we_o_w), .s_dbus_addr_o(addr_o), .s_dbus_be_o(be_o_w),
    .s_dbus_wdata_o(wdata_o), .s_dbus_gnt_i(gnt), .s_dbus_rvalid_i(rvalid),
    .s_dbus_rdata_i(brdata), .s_dbus_err_i(err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Runs one access from IDLE; gdly = REQ cycles without gnt, rvalid right after gnt.
  task automatic access(input logic st, input logic [1:0] sz, input logic un,
                        input logic [31:0] ad, input logic [31:0] wd, input int gdly,
                        input logic [31:0] rd, input logic er,
                        output int o_lat, output int o_reqc, output logic [31:0] o_addr,
                        output logic [3:0] o_be, output logic [31:0] o_wd, output logic o_we,
                        output logic [31:0] o_rd, output logic o_mis, output logic o_berr,
                        output logic o_sbad);
    logic granted;
    logic fin;
    o_lat = 0; o_reqc = 0; o_addr = '0; o_be = '0; o_wd = '0; o_we = 1'b0;
    o_rd = '0; o_mis = 1'b0; o_berr = 1'b0; granted = 1'b0; fin = 1'b0;
    valid = 1'b1; store = st; size = sz; uns = un; addr = ad; wdata = wd;
    #1;
    o_sbad = !stall_o;
    step();
    valid = 1'b0;
    o_lat = 1;
    while (!fin && o_lat < 40) begin
      gnt = 1'b0; rvalid = 1'b0; brdata = '0; err = 1'b0;
      #1;
      if (done_o) begin
        o_rd = rdata_o; o_mis = mis_o_w; o_berr = berr_o_w;
        if (stall_o) o_sbad = 1'b1;
        fin = 1'b1;
      end else begin
        if (!stall_o) o_sbad = 1'b1;
        if (req_o) begin
          o_reqc++;
          o_addr = addr_o; o_be = be_o_w; o_wd = wdata_o; o_we = we_o_w;
          if (o_reqc > gdly) begin
            gnt = 1'b1;
            granted = 1'b1;
          end
        end else if (granted) begin
          rvalid = 1'b1; brdata = rd; err = er; granted = 1'b0;
        end
        step();
        o_lat++;
      end
    end
    chk("access_bound", 32'(fin), 32'd1);
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; store = 1'b0; size = 2'd0; uns = 1'b0; flush = 1'b0;
    gnt = 1'b0; rvalid = 1'b0; err = 1'b0; addr = '0; wdata = '0; brdata = '0;
    step(); step();
    chk("rst_req", 32'(req_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_addr", addr_o, 32'd0);
    chk("rst_bus", {wdata_o[27:0], be_o_w}, 32'd0);
    chk("rst_flags", {28'd0, we_o_w, mis_o_w, berr_o_w, 1'b0}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    rst = 1'b0;
    step();

    // LB signed, zero-wait
    access(1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'd0, 0, 32'h80FF_FF00, 1'b0,
           lat, reqc, a_o, be_o, wd_o, we_o, rd_o, mis_o, berr_o, sbad);
    chk("lb_lat", 32'(lat), 32'd3);
    chk("lb_reqc", 32'(reqc), 32'd1);
    chk("lb_addr", a_o, 32'h0000_1000);
    chk("lb_be", 32'(be_o), 32'h8);
    chk("lb_we", 32'(we_o), 32'd0);
    chk("lb_rdata", rd_o, 32'hFFFF_FF80);
    chk("lb_flags", {30'd0, mis_o, berr_o}, 32'd0);
    chk("lb_stall", 32'(sbad), 32'd0);
    step();
    chk("lb_done_1cyc", 32'(done_o), 32'd0);
    chk("lb_rdata_clr", rdata_o, 32'd0);

    // LBU
    access(1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'd0, 0, 32'h80FF_FF00, 1'b0,
           lat, reqc, a_o, be_o, wd_o, we_o, rd_o, mis_o, berr_o, sbad);
    chk("lbu_rdata", rd_o, 32'h0000_0080);
    step();

    // SH with gnt after 3 cycles
    access(1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h1234_ABCD, 3, 32'hFFFF_FFFF, 1'b0,
           lat, reqc, a_o, be_o, wd_o, we_o, rd_o, mis_o, berr_o, sbad);
    chk("sh_reqc", 32'(reqc), 32'd4);
    chk("sh_lat", 32'(lat), 32'd6);
    chk("sh_addr", a_o, 32'h0000_2000);
    chk("sh_be", 32'(be_o), 32'hC);
    chk("sh_wdata", wd_o, 32'hABCD_ABCD);
    chk("sh_we", 32'(we_o), 32'd1);
    chk("sh_rdata", rd_o, 32'd0);
    chk("sh_stall", 32'(sbad), 32'd0);
    step();

    // SB
    access(1'b1, 2'd0, 1'b0, 32'h0000_1001, 32'h5566_77AB, 0, 32'd0, 1'b0,
           lat, reqc, a_o, be_o, wd_o, we_o, rd_o, mis_o, berr_o, sbad);
    chk("sb_be", 32'(be_o), 32'h2);
    chk("sb_wdata", wd_o, 32'hABAB_ABAB);
    step();

    // LH signed, upper half
    access(1'b0, 2'd1, 1'b0, 32'h0000_6002, 32'd0, 0, 32'h8001_1234, 1'b0,
           lat, reqc, a_o, be_o, wd_o, we_o, rd_o, mis_o, berr_o, sbad);
    chk("lh_be", 32'(be_o), 32'hC);
    chk("lh_rdata", rd_o, 32'hFFFF_8001);
    step();

    // LHU lower half
    access(1'b0, 2'd1, 1'b1, 32'h0000_6000, 32'd0, 0, 32'h8001_F234, 1'b0,
           lat, reqc, a_o, be_o, wd_o, we_o, rd_o, mis_o, berr_o, sbad);
    chk("lhu_be", 32'(be_o), 32'h3);
    chk("lhu_rdata", rd_o, 32'h0000_F234);
    step();

    // LW aligned
    access(1'b0, 2'd2, 1'b0, 32'h0000_7000, 32'd0, 1, 32'h1234_5678, 1'b0,
           lat, reqc, a_o, be_o, wd_o, we_o, rd_o, mis_o, berr_o, sbad);
    chk("lw_be", 32'(be_o), 32'hF);
    chk("lw_rdata", rd_o, 32'h1234_5678);
    chk("lw_lat", 32'(lat), 32'd4);
    step();

    // Misaligned word, reserved size, misaligned half
    access(1'b0, 2'd2, 1'b0, 32'h0000_3002, 32'd0, 0, 32'd0, 1'b0,
           lat, reqc, a_o, be_o, wd_o, we_o, rd_o, mis_o, berr_o, sbad);
    chk("mis_lw_lat", 32'(lat), 32'd1);
    chk("mis_lw_reqc", 32'(reqc), 32'd0);
    chk("mis_lw_flags", {30'd0, mis_o, berr_o}, 32'd2);
    chk("mis_lw_stall", 32'(sbad), 32'd0);
    step();
    access(1'b0, 2'd3, 1'b0, 32'h0000_3000, 32'd0, 0, 32'd0, 1'b0,
           lat, reqc, a_o, be_o, wd_o, we_o, rd_o, mis_o, berr_o, sbad);
    chk("mis_sz3", {24'd0, 8'(lat), 8'(reqc), 7'd0, mis_o}, 32'h0001_0001);
    step();
    access(1'b1, 2'd1, 1'b0, 32'h0000_3001, 32'd0, 0, 32'd0, 1'b0,
           lat, reqc, a_o, be_o, wd_o, we_o, rd_o, mis_o, berr_o, sbad);
    chk("mis_sh", {24'd0, 8'(lat), 8'(reqc), 7'd0, mis_o}, 32'h0001_0001);
    step();

    // Bus error
    access(1'b0, 2'd2, 1'b0, 32'h0000_5000, 32'd0, 0, 32'hDEAD_BEEF, 1'b1,
           lat, reqc, a_o, be_o, wd_o, we_o, rd_o, mis_o, berr_o, sbad);
    chk("err_flags", {30'd0, mis_o, berr_o}, 32'd1);
    chk("err_rdata", rd_o, 32'd0);
    step();

    // Timeout: gnt never comes
    access(1'b0, 2'd2, 1'b0, 32'h0000_5100, 32'd0, 1000, 32'd0, 1'b0,
           lat, reqc, a_o, be_o, wd_o, we_o, rd_o, mis_o, berr_o, sbad);
    chk("to_reqc", 32'(reqc), 32'd8);
    chk("to_lat", 32'(lat), 32'd9);
    chk("to_berr", 32'(berr_o), 32'd1);
    chk("to_req_drop", 32'(req_o), 32'd0);
    step();

    // Flush while in WAIT
    valid = 1'b1; store = 1'b0; size = 2'd2; uns = 1'b0; addr = 32'h0000_4000;
    step();
    valid = 1'b0;
    chk("fl_req", 32'(req_o), 32'd1);
    gnt = 1'b1;
    step();
    gnt = 1'b0; flush = 1'b1;
    chk("fl_wait_stall", 32'(stall_o), 32'd1);
    step();
    flush = 1'b0;
    chk("fl_t3", {30'd0, done_o, stall_o}, 32'd1);
    step();
    rvalid = 1'b1; brdata = 32'h1111_1111;
    chk("fl_t4", {30'd0, done_o, stall_o}, 32'd1);
    step();
    rvalid = 1'b0; brdata = '0;
    chk("fl_no_done", {29'd0, done_o, stall_o, req_o}, 32'd0);
    access(1'b0, 2'd2, 1'b0, 32'h0000_4004, 32'd0, 0, 32'hCAFE_F00D, 1'b0,
           lat, reqc, a_o, be_o, wd_o, we_o, rd_o, mis_o, berr_o, sbad);
    chk("fl_next_lat", 32'(lat), 32'd3);
    chk("fl_next_addr", a_o, 32'h0000_4004);
    chk("fl_next_rdata", rd_o, 32'hCAFE_F00D);
    step();

    // Reset while in WAIT, then a late rvalid
    valid = 1'b1; store = 1'b1; size = 2'd2; addr = 32'h0000_8000; wdata = 32'h0BAD_CAFE;
    step();
    valid = 1'b0;
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    chk("rw_wait_stall", 32'(stall_o), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0; rvalid = 1'b1; brdata = 32'hFFFF_FFFF;
    chk("rw_ctl", {28'd0, req_o, done_o, stall_o, we_o_w}, 32'd0);
    chk("rw_addr", addr_o, 32'd0);
    chk("rw_wdata", wdata_o, 32'd0);
    chk("rw_be", 32'(be_o_w), 32'd0);
    step();
    rvalid = 1'b0; brdata = '0;
    chk("rw_late", {29'd0, done_o, req_o, berr_o_w}, 32'd0);
    chk("rw_late_rdata", rdata_o, 32'd0);
    access(1'b0, 2'd0, 1'b1, 32'h0000_9002, 32'd0, 0, 32'h00AB_0000, 1'b0,
           lat, reqc, a_o, be_o, wd_o, we_o, rd_o, mis_o, berr_o, sbad);
    chk("rw_recover", rd_o, 32'h0000_00AB);
    step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
